// File: rtl/axis_upsizer_lane_ctrl.sv
// Lane sequencing for the narrow-to-wide AXIS upsizer: steers narrow beats round-robin into
// per-lane FIFOs, pads short packets and pops all lanes together. Optional: UPSIZER_FLUSH_TIMEOUT_EN.
module axis_upsizer_lane_ctrl #(
  parameter int DATA_RATIO   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_RATIO-1:0] lane_wen,
  input  logic [DATA_RATIO-1:0] lane_wfull,
  output logic [DATA_RATIO-1:0] lane_ren,
  input  logic [DATA_RATIO-1:0] lane_rempty,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [DATA_RATIO-1:0] m_axis_tkeep,
  input  logic                  m_axis_tready
);

  localparam int PW    = $clog2(DATA_RATIO);
  localparam int CW    = $clog2(DATA_RATIO + 1);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [PW-1:0] PTR_MAX  = PW'(DATA_RATIO - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DATA_RATIO);

  typedef enum logic {FILL, PAD} state_t;
  typedef struct packed {
    logic          last;
    logic [CW-1:0] cnt;
  } meta_t;

  // Handshake: a narrow beat transfers on s_axis_tvalid && s_axis_tready, a wide beat on
  // m_axis_tvalid && m_axis_tready; neither ready depends on its own valid.
  state_t          state, state_d;
  logic [PW-1:0]   ptr, ptr_d;
  logic [CW-1:0]   k, k_d;
  logic            pad_last, pad_last_d;
  logic            run_q;
  logic            accept, at_end, flush_hit;
  logic [DATA_RATIO-1:0] ptr_onehot;

  logic            push, pop;
  meta_t           push_meta, head;
  meta_t           meta_mem [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr, rd_ptr;
  logic            meta_full, meta_empty;

  assign at_end     = (ptr == PTR_MAX);
  assign ptr_onehot = {{(DATA_RATIO-1){1'b0}}, 1'b1} << ptr;

  // run_q keeps the input closed until the first edge after reset release.
  assign s_axis_tready = run_q && (state == FILL) && !lane_wfull[ptr] && !meta_full;
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= FILL;
      ptr      <= '0;
      k        <= '0;
      pad_last <= 1'b1;
      run_q    <= 1'b0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      k        <= k_d;
      pad_last <= pad_last_d;
      run_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    k_d        = k;
    pad_last_d = pad_last;
    lane_wen   = '0;
    push       = 1'b0;
    push_meta  = '0;
    case (state)
      FILL: begin
        if (accept) begin
          lane_wen = ptr_onehot;
          if (at_end) begin
            push           = 1'b1;
            push_meta.last = s_axis_tlast;
            push_meta.cnt  = CNT_FULL;
            ptr_d          = '0;
          end else if (s_axis_tlast) begin
            k_d        = CW'(ptr) + 1'b1;
            pad_last_d = 1'b1;
            ptr_d      = ptr + 1'b1;
            state_d    = PAD;
          end else begin
            ptr_d = ptr + 1'b1;
          end
        end else if (flush_hit) begin
          k_d        = CW'(ptr);
          pad_last_d = 1'b0;
          state_d    = PAD;
        end
      end
      PAD: begin
        // The word-completing dummy write also needs a free metadata slot.
        if (!lane_wfull[ptr] && (!at_end || !meta_full)) begin
          lane_wen = ptr_onehot;
          if (at_end) begin
            push           = 1'b1;
            push_meta.last = pad_last;
            push_meta.cnt  = k;
            ptr_d          = '0;
            state_d        = FILL;
          end else begin
            ptr_d = ptr + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

`ifdef UPSIZER_FLUSH_TIMEOUT_EN
  localparam int IW = $clog2(FLUSH_CYCLES + 1);
  logic [IW-1:0] idle_cnt;

  assign flush_hit = (state == FILL) && !accept && (ptr != '0) &&
                     (idle_cnt == IW'(FLUSH_CYCLES - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      idle_cnt <= '0;
    end else if ((state != FILL) || accept || (ptr == '0) || (state_d == PAD)) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign flush_hit = 1'b0;
`endif

  // Metadata queue: one entry per completed word, head describes the next wide beat.
  assign meta_empty = (wr_ptr == rd_ptr);
  assign meta_full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                      (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign head       = meta_mem[rd_ptr[ADDR_WIDTH-1:0]];

  always_ff @(posedge aclk) begin
    if (push) meta_mem[wr_ptr[ADDR_WIDTH-1:0]] <= push_meta;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (aresetn) assert (DATA_RATIO >= 2 && FLUSH_CYCLES >= 1 && !(push && meta_full));
  end

  assign m_axis_tvalid = !meta_empty && (lane_rempty == '0);
  assign m_axis_tlast  = !meta_empty && head.last;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign lane_ren      = {DATA_RATIO{pop}};

  always_comb begin
    m_axis_tkeep = '0;
    for (int i = 0; i < DATA_RATIO; i++) begin
      m_axis_tkeep[i] = !meta_empty && (CW'(i) < head.cnt);
    end
  end

endmodule

// File: tb/tb_axis_upsizer_lane_ctrl.sv
// Randomized bench for axis_upsizer_lane_ctrl: models the lane FIFOs and predicts wide beats
// by chunking each packet into DATA_RATIO-beat words. Honours UPSIZER_FLUSH_TIMEOUT_EN.
module tb_axis_upsizer_lane_ctrl;
  localparam int DR = 8;
  localparam int AW = 4;
  localparam int FC = 16;
  localparam int FD = 2 ** AW;
  localparam int DW = 8 * DR;
  localparam int EW = 1 + DR + DW;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [DR-1:0] lane_wen, lane_wfull, lane_ren, lane_rempty;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [DR-1:0] m_axis_tkeep;

  always #5 aclk = ~aclk;

  axis_upsizer_lane_ctrl #(.DATA_RATIO(DR), .ADDR_WIDTH(AW), .FLUSH_CYCLES(FC)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .lane_wen(lane_wen), .lane_wfull(lane_wfull),
    .lane_ren(lane_ren), .lane_rempty(lane_rempty),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tready(m_axis_tready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lane FIFO models (FWFT, flags visible the cycle after the write/read edge).
  logic [7:0]    lane_mem [DR][FD];
  int            lane_wp [DR];
  int            lane_rp [DR];
  int            lane_cnt [DR];

  logic [8:0]    pend_q[$];
  logic [7:0]    word_q[$];
  logic [EW-1:0] exp_q[$];

  int   exp_lane, idle, cyc, n_out, n_acc, n_stall, n_pad, n_valid;
  int   wr7_cyc, last_lat, last_acc_cyc, first_pad_cyc;
  int   vprob = 100;
  int   rprob = 100;
  bit   padding, prev_hold, prev_valid;
  logic [DR:0] prev_meta;
  logic [7:0]  cur_data;

  task automatic clear_model();
    for (int i = 0; i < DR; i++) begin
      lane_wp[i] = 0; lane_rp[i] = 0; lane_cnt[i] = 0;
    end
    pend_q.delete(); word_q.delete(); exp_q.delete();
    exp_lane = 0; idle = 0; padding = 0; prev_hold = 0; prev_valid = 0;
  endtask

  task automatic emit(input bit last);
    logic [DW-1:0] d;
    logic [DR-1:0] keep;
    d = '0; keep = '0;
    for (int i = 0; i < word_q.size(); i++) begin
      d[i*8 +: 8] = word_q[i];
      keep[i]     = 1'b1;
    end
    exp_q.push_back({last, keep, d});
    word_q.delete();
  endtask

  task automatic push_pkt(input int len, input bit with_last);
    for (int i = 1; i <= len; i++) pend_q.push_back({with_last && (i == len), 8'($urandom)});
  endtask

  task automatic observe();
    bit            acc, pop;
    logic [DR-1:0] one_hot;
    logic [DW-1:0] d;
    int            empt, ovf;
    acc = s_axis_tvalid && s_axis_tready;
    pop = m_axis_tvalid && m_axis_tready;

    check("lane_ren", lane_ren, pop ? {DR{1'b1}} : {DR{1'b0}});
    if (padding) check("pad_tready", s_axis_tready, 1'b0);
    if (s_axis_tvalid && !s_axis_tready) n_stall++;
    if (m_axis_tvalid) n_valid++;
    if (prev_hold) begin
      check("hold_valid", m_axis_tvalid, 1'b1);
      check("hold_meta", {m_axis_tlast, m_axis_tkeep}, prev_meta);
    end
    prev_hold = m_axis_tvalid && !m_axis_tready;
    prev_meta = {m_axis_tlast, m_axis_tkeep};
    if (m_axis_tvalid && !prev_valid) last_lat = cyc - wr7_cyc;
    prev_valid = m_axis_tvalid;

    if (pop) begin
      d = '0; empt = 0;
      for (int i = 0; i < DR; i++) begin
        if (lane_cnt[i] == 0) empt++;
        else begin
          if (m_axis_tkeep[i]) d[i*8 +: 8] = lane_mem[i][lane_rp[i]];
          lane_rp[i] = (lane_rp[i] + 1) % FD;
          lane_cnt[i]--;
        end
      end
      check("lanes_nonempty_on_pop", empt, 0);
      n_out++;
      if (exp_q.size() == 0) check("sb_unexpected_beat", exp_q.size(), 1);
      else check("sb_beat", {m_axis_tlast, m_axis_tkeep, d}, exp_q.pop_front());
    end

    if (lane_wen != '0 || acc) begin
      one_hot = '0;
      one_hot[exp_lane] = 1'b1;
      check("wen_lane", lane_wen, one_hot);
      if (!acc) begin
        n_pad++;
        if (first_pad_cyc < 0) first_pad_cyc = cyc;
        check("pad_allowed", padding, 1'b1);
      end
      ovf = 0;
      for (int i = 0; i < DR; i++) begin
        if (lane_wen[i]) begin
          if (lane_cnt[i] >= FD) ovf++;
          else begin
            lane_mem[i][lane_wp[i]] = cur_data;
            lane_wp[i] = (lane_wp[i] + 1) % FD;
            lane_cnt[i]++;
          end
        end
      end
      check("lane_no_overflow", ovf, 0);
      if (lane_wen[DR-1]) wr7_cyc = cyc;
      if (acc) begin
        n_acc++;
        last_acc_cyc = cyc;
        idle = 0;
        word_q.push_back(cur_data);
        void'(pend_q.pop_front());
        if (s_axis_tlast) begin
          emit(1'b1);
          padding = (exp_lane != DR - 1);
        end else if (word_q.size() == DR) begin
          emit(1'b0);
        end
      end
      exp_lane = (exp_lane + 1) % DR;
      if (exp_lane == 0) padding = 0;
    end else if (!padding && exp_lane != 0) begin
`ifdef UPSIZER_FLUSH_TIMEOUT_EN
      idle++;
      if (idle == FC) begin
        emit(1'b0);
        padding = 1;
        idle = 0;
      end
`endif
    end
  endtask

  task automatic step();
    @(negedge aclk);
    for (int i = 0; i < DR; i++) begin
      lane_wfull[i]  = (lane_cnt[i] >= FD);
      lane_rempty[i] = (lane_cnt[i] == 0);
    end
    s_axis_tvalid = (pend_q.size() != 0) && ($urandom_range(99) < vprob);
    s_axis_tlast  = (pend_q.size() != 0) ? pend_q[0][8] : 1'b0;
    cur_data      = (pend_q.size() != 0) ? pend_q[0][7:0] : 8'($urandom);
    m_axis_tready = ($urandom_range(99) < rprob);
    #1;
    observe();
    cyc++;
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while ((pend_q.size() != 0 || exp_q.size() != 0) && b > 0) begin
      step();
      b--;
    end
    check("drain_done", pend_q.size() + exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    @(negedge aclk);
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    clear_model();
    lane_wfull    = '0;
    lane_rempty   = '1;
    #1;
    check("rst_s_tready", s_axis_tready, 1'b0);
    check("rst_lane_wen", lane_wen, {DR{1'b0}});
    check("rst_lane_ren", lane_ren, {DR{1'b0}});
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_m_tlast", m_axis_tlast, 1'b0);
    check("rst_m_tkeep", m_axis_tkeep, {DR{1'b0}});
    repeat (2) @(negedge aclk);
    check("rst_hold_s_tready", s_axis_tready, 1'b0);
    aresetn = 1'b1;
  endtask

  initial begin
    int o0, s0, p0, a0, v0, bound;
    s_axis_tvalid = 0; s_axis_tlast = 0; m_axis_tready = 0;
    cyc = 0; n_out = 0; n_acc = 0; n_stall = 0; n_pad = 0; n_valid = 0;
    wr7_cyc = 0; last_lat = -1; last_acc_cyc = 0; first_pad_cyc = -1;
    clear_model();
    apply_reset();
    repeat (2) step();

    // Two full words, no backpressure.
    vprob = 100; rprob = 100; o0 = n_out; s0 = n_stall;
    push_pkt(16, 1'b1);
    drain(200);
    check("t1_no_stall", n_stall - s0, 0);
    check("t1_beats", n_out - o0, 2);

    // Short packet padded to a full word.
    o0 = n_out; p0 = n_pad;
    push_pkt(3, 1'b1);
    drain(200);
    check("t2_pad_cycles", n_pad - p0, 5);
    check("t2_latency", last_lat, 1);
    check("t2_beats", n_out - o0, 1);

    // One-beat packet followed by a full packet.
    o0 = n_out;
    push_pkt(1, 1'b1);
    push_pkt(8, 1'b1);
    drain(200);
    check("t3_beats", n_out - o0, 2);

    // Output blocked: metadata queue and lane FIFOs fill up.
    rprob = 0; o0 = n_out; a0 = n_acc;
    push_pkt(136, 1'b1);
    repeat (200) step();
    check("t4_accepted", n_acc - a0, 128);
    check("t4_queued", exp_q.size(), 16);
    check("t4_tready_low", s_axis_tready, 1'b0);
    check("t4_no_output", n_out - o0, 0);
    rprob = 100;
    drain(500);
    check("t4_beats", n_out - o0, 17);

    // Random traffic with light and heavy backpressure.
    vprob = 70; rprob = 60;
    for (int p = 0; p < 25; p++) push_pkt($urandom_range(1, 20), 1'b1);
    drain(5000);
    vprob = 90; rprob = 25;
    for (int p = 0; p < 25; p++) push_pkt($urandom_range(1, 24), 1'b1);
    drain(8000);

    // Reset in the middle of a packet after five beats.
    vprob = 100; rprob = 100; a0 = n_acc;
    push_pkt(12, 1'b1);
    bound = 100;
    while (n_acc - a0 < 5 && bound > 0) begin
      step();
      bound--;
    end
    check("t5_pre_accepts", n_acc - a0, 5);
    apply_reset();
    o0 = n_out;
    repeat (2) step();
    push_pkt(10, 1'b1);
    drain(300);
    check("t5_beats", n_out - o0, 2);

    // Partial word left idle.
    o0 = n_out; p0 = n_pad; v0 = n_valid; first_pad_cyc = -1;
    push_pkt(2, 1'b0);
    repeat (60) step();
`ifdef UPSIZER_FLUSH_TIMEOUT_EN
    check("t6_flush_beats", n_out - o0, 1);
    check("t6_pad_cycles", n_pad - p0, 6);
    check("t6_flush_delay", first_pad_cyc - last_acc_cyc, FC + 1);
    check("t6_queue_empty", exp_q.size(), 0);
`else
    check("t6_no_beat", n_out - o0, 0);
    check("t6_no_valid", n_valid - v0, 0);
    check("t6_no_pad", n_pad - p0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axis_upsizer_lane_ctrl.md
Name: axis_upsizer_lane_ctrl

Overview:
Sequencing controller for the lane-FIFO upsizer datapath: DATA_RATIO narrow sync FIFOs, one per output lane.
- Steers each accepted narrow AXIS beat into the next lane FIFO in round-robin order.
- Pads short packets so all lanes stay word-aligned.
- Tracks per-word last/keep metadata, and pops all lanes together to form one wide beat.
- The data path is external: s_axis_tdata is broadcast to every lane FIFO wdata, and m_axis_tdata is the concatenation of lane rdata, with lane 0 in the LSBs.

Parameters:
- DATA_RATIO, 8, number of lanes (narrow beats per wide beat); must be at least 2.
- ADDR_WIDTH, 4, lane FIFO address width; the internal metadata queue depth is 2**ADDR_WIDTH.
- FLUSH_CYCLES, 16, idle-cycle timeout used only when UPSIZER_FLUSH_TIMEOUT_EN is defined; must be at least 1.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tvalid  in  1  narrow beat valid
- s_axis_tlast  in  1  narrow beat ends packet
- s_axis_tready  out  1  narrow beat accept
- lane_wen  out  DATA_RATIO  one-hot lane FIFO write enable
- lane_wfull  in  DATA_RATIO  lane FIFO full flags
- lane_ren  out  DATA_RATIO  lane FIFO read enables (all bits equal)
- lane_rempty  in  DATA_RATIO  lane FIFO empty flags (FIFOs are first-word-fall-through)
- m_axis_tvalid  out  1  wide beat valid
- m_axis_tlast  out  1  wide beat ends packet
- m_axis_tkeep  out  DATA_RATIO  per-lane valid, thermometer code from bit 0
- m_axis_tready  in  1  wide beat accept

Behaviour:
- Reset (async assert, sync deassert expected upstream):
  - state=FILL, ptr=0, metadata queue empty.
  - Outputs: s_axis_tready, lane_wen, lane_ren, m_axis_tvalid, m_axis_tlast, m_axis_tkeep are all 0.
  - Lane FIFOs share aresetn. Reset mid-packet discards all partial and queued words with no flush.
- Write side FSM, ptr in 0..DATA_RATIO-1:
  - FILL:
    - s_axis_tready = !lane_wfull[ptr] && !meta_full (combinational).
    - On accept: lane_wen[ptr]=1 in the same cycle.
    - If ptr==DATA_RATIO-1: push meta{last=tlast, cnt=DATA_RATIO}, ptr<=0, stay FILL.
    - Else if tlast: k<=ptr+1 (count of real beats), ptr<=ptr+1, go to PAD.
    - Else: ptr<=ptr+1.
  - PAD:
    - s_axis_tready=0.
    - Each cycle with !lane_wfull[ptr] (and, when ptr==DATA_RATIO-1, !meta_full), write a dummy beat: lane_wen[ptr]=1, ptr<=ptr+1.
    - The write at ptr==DATA_RATIO-1 pushes meta{last=1, cnt=k}, ptr<=0, go to FILL.
    - A stall on a full lane holds ptr.
  - Pad cost is DATA_RATIO-k cycles. tlast on lane DATA_RATIO-1 needs no pad.
- Metadata queue:
  - Depth 2**ADDR_WIDTH, entries {last, cnt}, cnt width clog2(DATA_RATIO+1).
  - Simultaneous push and pop leaves the count unchanged.
  - meta_full blocks any write that would complete a word.
  - Push while full never occurs (assert in sim).
- Read side (combinational):
  - m_axis_tvalid = meta nonempty && (lane_rempty == 0).
  - m_axis_tlast = head.last.
  - m_axis_tkeep bit i = (i < head.cnt).
  - Pop when m_axis_tvalid && m_axis_tready: lane_ren = all ones and metadata pop in the same cycle.
  - m_axis_tvalid held stable until accepted.
- Latency: the earliest m_axis_tvalid is the cycle after the last lane write of a word (one cycle, FWFT FIFO with registered empty). No read when any lane is empty, even if meta is nonempty.
- Throughput: 1 narrow beat/cycle in, 1 wide beat/cycle out, with no bubbles while there are no pads or full/empty stalls.

Optional Feature:
UPSIZER_FLUSH_TIMEOUT_EN.
- Defined:
  - An idle counter counts cycles in FILL with ptr!=0 and no accept; it resets on any accept.
  - On reaching FLUSH_CYCLES, the FSM enters PAD with k=ptr and pads to completion.
  - The pushed meta has last=0, cnt=k (partial, non-final word).
  - The counter is cleared on reset and on entering PAD.
- Undefined: no counter, and a partial word waits indefinitely for more beats or tlast. FLUSH_CYCLES is ignored.

Test Plan:
- DATA_RATIO=8, 16 beats, tlast on beat 16, m_tready=1 -> 2 wide beats, tkeep=0xFF both, tlast=0 then 1, no s_tready deassertion.
- 3-beat packet (tlast on beat 3) -> 5 pad cycles with s_tready=0, lane_wen 0x08..0x80. Then one wide beat, tkeep=0x07, tlast=1, lanes 0-2 carry the input data.
- 1-beat packet immediately followed by an 8-beat packet -> beat 1 tkeep=0x01 tlast=1; beat 2 tkeep=0xFF tlast=1; second packet data starts in lane 0.
- m_tready=0 while streaming -> after 16 complete words meta_full; s_tready=0 when ptr would complete word 17 (lane FIFOs full). Release m_tready -> 16 pops in order, no loss or duplication.
- aresetn pulsed low mid-packet at ptr=5 -> all outputs 0 during reset; post-reset the first packet lands at lane 0, no stale wide beat emitted.
- With UPSIZER_FLUSH_TIMEOUT_EN, FLUSH_CYCLES=16: 2 beats then idle -> after 16 idle cycles 6 pad writes, wide beat tkeep=0x03 tlast=0. Without the macro, no output beat ever appears.
